// File: rtl/tiny_dnn_seq.sv
// tiny_dnn_seq: loop sequencer walking output neurons and their input terms for the MAC datapath.
// Optional macro TINY_DNN_SEQ_CONV_EN switches the source addressing to a convolution window walk.
module tiny_dnn_seq #(
    parameter int AW    = 12,
    parameter int WAW   = 16,
    parameter int DRAIN = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           run,
    input  logic           src_bank,
    input  logic           dst_bank,
    input  logic           acc_en,
    input  logic [AW:0]    ss,
    input  logic [AW:0]    ds,
    input  logic [AW-1:0]  src_base,
    input  logic [3:0]     kw,
    input  logic [3:0]     kh,
    input  logic [AW-1:0]  iw,
    output logic           busy,
    output logic           done,
    output logic           exec,
    output logic [AW:0]    ia,
    output logic           init,
    output logic [WAW-1:0] wa,
    output logic           outr,
    output logic           accr,
    output logic [AW:0]    oa
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t         state_r, state_n;
    logic           cfg_src_bank_r, cfg_dst_bank_r, cfg_acc_en_r;
    logic [AW:0]    cfg_ds_r;
    logic [AW-1:0]  cfg_src_base_r;
    logic           idle_s, src_bank_s, dst_bank_s, acc_en_s;
    logic [AW:0]    ds_s;
    logic [AW-1:0]  src_base_s;
    logic [AW-1:0]  o_r, o_n, addr_n;
    logic [7:0]     dcnt_r, dcnt_n;
    logic           empty_s, term_last_s, out_last_s, first_n, last_n;
    logic           busy_n, done_n, exec_n, init_n, outr_n, accr_n;
    logic [AW:0]    ia_n, oa_n;
    logic [WAW-1:0] wa_n;

    // Config is transparent while idle so the accepting cycle already uses the new values
    assign idle_s     = (state_r == S_IDLE);
    assign src_bank_s = idle_s ? src_bank : cfg_src_bank_r;
    assign dst_bank_s = idle_s ? dst_bank : cfg_dst_bank_r;
    assign acc_en_s   = idle_s ? acc_en   : cfg_acc_en_r;
    assign ds_s       = idle_s ? ds       : cfg_ds_r;
    assign src_base_s = idle_s ? src_base : cfg_src_base_r;
    assign out_last_s = ({1'b0, o_r} == ds_s - (AW+1)'(1));

    // Common config capture, frozen once a run is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_src_bank_r <= 1'b0;
            cfg_dst_bank_r <= 1'b0;
            cfg_acc_en_r   <= 1'b0;
            cfg_ds_r       <= (AW+1)'(0);
            cfg_src_base_r <= AW'(0);
        end else if (idle_s) begin
            cfg_src_bank_r <= src_bank;
            cfg_dst_bank_r <= dst_bank;
            cfg_acc_en_r   <= acc_en;
            cfg_ds_r       <= ds;
            cfg_src_base_r <= src_base;
        end
    end

`ifdef TINY_DNN_SEQ_CONV_EN
    logic [3:0]    cfg_kw_r, cfg_kh_r, kw_s, kh_s, kx_r, kx_n, ky_r, ky_n;
    logic [AW-1:0] cfg_iw_r, iw_s, ox_r, ox_n, base_r, base_n, row_r, row_n;
    logic          unused_cfg_s;

    assign unused_cfg_s = ^ss;
    assign kw_s         = idle_s ? kw : cfg_kw_r;
    assign kh_s         = idle_s ? kh : cfg_kh_r;
    assign iw_s         = idle_s ? iw : cfg_iw_r;
    assign empty_s      = (kw_s == 4'd0) || (kh_s == 4'd0) || (ds_s == (AW+1)'(0));
    assign term_last_s  = (kx_r == kw_s - 4'd1) && (ky_r == kh_s - 4'd1);

    // Window walk: base tracks the output corner, row tracks the current kernel row start
    always_comb begin
        kx_n = kx_r; ky_n = ky_r; ox_n = ox_r; o_n = o_r; base_n = base_r; row_n = row_r;
        if (idle_s) begin
            kx_n = 4'd0; ky_n = 4'd0; ox_n = AW'(0); o_n = AW'(0);
            base_n = src_base_s; row_n = src_base_s;
        end else if (state_r == S_RUN) begin
            if (term_last_s) begin
                kx_n = 4'd0; ky_n = 4'd0; o_n = o_r + AW'(1);
                if (ox_r == iw_s - AW'(kw_s)) begin
                    ox_n = AW'(0); base_n = base_r + AW'(kw_s);
                end else begin
                    ox_n = ox_r + AW'(1); base_n = base_r + AW'(1);
                end
                row_n = base_n;
            end else if (kx_r == kw_s - 4'd1) begin
                kx_n = 4'd0; ky_n = ky_r + 4'd1; row_n = row_r + iw_s;
            end else begin
                kx_n = kx_r + 4'd1;
            end
        end else begin
            kx_n = kx_r;
        end
    end

    assign addr_n  = row_n + AW'(kx_n);
    assign first_n = (kx_n == 4'd0) && (ky_n == 4'd0);
    assign last_n  = (kx_n == kw_s - 4'd1) && (ky_n == kh_s - 4'd1);

    // Window counters and kernel config
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_kw_r <= 4'd0; cfg_kh_r <= 4'd0; cfg_iw_r <= AW'(0);
            kx_r <= 4'd0; ky_r <= 4'd0; ox_r <= AW'(0); base_r <= AW'(0); row_r <= AW'(0);
        end else begin
            if (idle_s) begin
                cfg_kw_r <= kw; cfg_kh_r <= kh; cfg_iw_r <= iw;
            end
            kx_r <= kx_n; ky_r <= ky_n; ox_r <= ox_n; base_r <= base_n; row_r <= row_n;
        end
    end
`else
    logic [AW:0]   cfg_ss_r, ss_s;
    logic [AW-1:0] i_r, i_n;
    logic          unused_cfg_s;

    assign unused_cfg_s = ^{kw, kh, iw};
    assign ss_s         = idle_s ? ss : cfg_ss_r;
    assign empty_s      = (ss_s == (AW+1)'(0)) || (ds_s == (AW+1)'(0));
    assign term_last_s  = ({1'b0, i_r} == ss_s - (AW+1)'(1));

    // Linear term/output counters
    always_comb begin
        i_n = i_r; o_n = o_r;
        if (idle_s) begin
            i_n = AW'(0); o_n = AW'(0);
        end else if (state_r == S_RUN) begin
            if (term_last_s) begin
                i_n = AW'(0); o_n = o_r + AW'(1);
            end else begin
                i_n = i_r + AW'(1);
            end
        end else begin
            i_n = i_r;
        end
    end

    assign addr_n  = src_base_s + i_n;
    assign first_n = (i_n == AW'(0));
    assign last_n  = ({1'b0, i_n} == ss_s - (AW+1)'(1));

    // Term counter and term-count config
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_ss_r <= (AW+1)'(0);
            i_r      <= AW'(0);
        end else begin
            if (idle_s) begin
                cfg_ss_r <= ss;
            end
            i_r <= i_n;
        end
    end
`endif

    // State, output counter and drain counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            o_r     <= AW'(0);
            dcnt_r  <= 8'd0;
        end else begin
            state_r <= state_n;
            o_r     <= o_n;
            dcnt_r  <= dcnt_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state_r;
        dcnt_n  = 8'd0;
        case (state_r)
            S_IDLE: begin
                if (run) state_n = empty_s ? S_FIN : S_RUN;
                else     state_n = S_IDLE;
            end
            S_RUN: begin
                if (term_last_s && out_last_s) state_n = (DRAIN == 0) ? S_FIN : S_DRAIN;
                else                           state_n = S_RUN;
            end
            S_DRAIN: begin
                if (dcnt_r == 8'(DRAIN - 1)) state_n = S_FIN;
                else                         dcnt_n  = dcnt_r + 8'd1;
            end
            S_FIN:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Next values of the registered outputs, describing the cycle that state_n will own
    always_comb begin
        busy_n = (state_n == S_RUN) || (state_n == S_DRAIN);
        done_n = (state_n == S_FIN);
        exec_n = (state_n == S_RUN);
        init_n = exec_n && first_n;
        outr_n = exec_n && last_n;
        accr_n = outr_n && acc_en_s;
        if (exec_n) ia_n = {src_bank_s, addr_n};
        else        ia_n = ia;
        if (outr_n) oa_n = {dst_bank_s, o_n};
        else        oa_n = oa;
        if (idle_s)      wa_n = WAW'(0);
        else if (exec_n) wa_n = wa + WAW'(1);
        else             wa_n = wa;
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0; done <= 1'b0; exec <= 1'b0; init <= 1'b0; outr <= 1'b0; accr <= 1'b0;
            ia   <= (AW+1)'(0); oa <= (AW+1)'(0); wa <= WAW'(0);
        end else begin
            busy <= busy_n; done <= done_n; exec <= exec_n; init <= init_n; outr <= outr_n; accr <= accr_n;
            ia   <= ia_n; oa <= oa_n; wa <= wa_n;
        end
    end
endmodule
